// File: rtl/matvec_param_stream.sv
// rtl/matvec_param_stream.sv - streamed M x N signed matrix-vector multiplier, one row result per output beat
// Loads W (optional) then x over one stream, computes each row through a pipelined multiply-accumulate.
module matvec_param_stream #(
    parameter int M           = 8,
    parameter int N           = 8,
    parameter int WIDTH       = 14,
    parameter int MULT_STAGES = 2,
    parameter int RELU        = 0,
    localparam int ACC_W      = 2*WIDTH + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [WIDTH-1:0]        input_data,
    input  logic                    new_matrix,
    output logic                    output_valid,
    input  logic                    output_ready,
    output logic [ACC_W-1:0]        output_data,
    output logic                    output_last
);
    localparam int PW = 2*WIDTH;
    localparam int MA = $clog2(M*N);
    localparam int XW = $clog2(N);
    localparam int CW = $clog2(N+1);
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_COMPUTE, S_OUTPUT} state_t;

    state_t                   state_q, state_d;
    logic                     w_loaded_q, w_loaded_d;
    logic [MA-1:0]            ld_cnt_q, ld_cnt_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [MA-1:0]            base_q, base_d;
    logic                     input_ready_q, input_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic signed [ACC_W-1:0]  out_data_q, out_data_d;

    logic signed [WIDTH-1:0]  w_mem [M*N];
    logic signed [WIDTH-1:0]  x_mem [N];
    logic signed [WIDTH-1:0]  w_rd_q, x_rd_q;

    logic                     in_fire, out_fire;
    logic                     w_we, x_we;
    logic [MA-1:0]            wr_addr;
    logic                     rd_en, rd_first, rd_last;
    logic [MA-1:0]            rd_waddr;
    logic [XW-1:0]            rd_xaddr;
    logic                     rd_vld_q, rd_first_q, rd_last_q;

    logic signed [PW-1:0]     prod_c, m_prod;
    logic                     m_vld, m_first, m_last;
    logic signed [ACC_W-1:0]  acc_q, prod_ext;
    logic                     acc_done_q;

    assign in_fire      = reset && input_valid && input_ready_q;
    assign out_fire     = out_valid_q && output_ready;
    assign input_ready  = input_ready_q;
    assign output_valid = out_valid_q;
    assign output_last  = out_last_q;
    assign output_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        w_loaded_d  = w_loaded_q;
        ld_cnt_d    = ld_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        base_d      = base_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        w_we        = 1'b0;
        x_we        = 1'b0;
        wr_addr     = ld_cnt_q;
        rd_en       = 1'b0;
        rd_waddr    = base_q + MA'(col_q);
        rd_xaddr    = col_q[XW-1:0];
        rd_first    = (col_q == '0);
        rd_last     = (col_q == CW'(N-1));
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    wr_addr  = '0;
                    ld_cnt_d = MA'(1);
                    if (new_matrix || !w_loaded_q) begin
                        w_we    = 1'b1;
                        state_d = S_LOAD_W;
                    end else begin
                        x_we    = 1'b1;
                        state_d = S_LOAD_X;
                    end
                end
            end
            S_LOAD_W: begin
                if (in_fire) begin
                    w_we = 1'b1;
                    if (ld_cnt_q == MA'(M*N-1)) begin
                        w_loaded_d = 1'b1;
                        ld_cnt_d   = '0;
                        state_d    = S_LOAD_X;
                    end else begin
                        ld_cnt_d = ld_cnt_q + MA'(1);
                    end
                end
            end
            S_LOAD_X: begin
                if (in_fire) begin
                    x_we = 1'b1;
                    if (ld_cnt_q == MA'(N-1)) begin
                        ld_cnt_d = '0;
                        col_d    = '0;
                        row_d    = '0;
                        base_d   = '0;
                        state_d  = S_COMPUTE;
                    end else begin
                        ld_cnt_d = ld_cnt_q + MA'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (col_q < CW'(N)) begin
                    rd_en = 1'b1;
                    col_d = col_q + CW'(1);
                end
                if (acc_done_q) begin
                    out_valid_d = 1'b1;
                    out_last_d  = (row_q == RW'(M-1));
                    out_data_d  = (RELU != 0 && acc_q[ACC_W-1]) ? '0 : acc_q;
                    state_d     = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (row_q == RW'(M-1)) begin
                        state_d = S_IDLE;
                    end else begin
                        // The handshake cycle itself issues column 0 of the next row.
                        rd_en    = 1'b1;
                        rd_waddr = base_q + MA'(N);
                        rd_xaddr = '0;
                        rd_first = 1'b1;
                        rd_last  = 1'b0;
                        base_d   = base_q + MA'(N);
                        row_d    = row_q + RW'(1);
                        col_d    = CW'(1);
                        state_d  = S_COMPUTE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        input_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_W) || (state_d == S_LOAD_X);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            w_loaded_q    <= 1'b0;
            ld_cnt_q      <= '0;
            col_q         <= '0;
            row_q         <= '0;
            base_q        <= '0;
            input_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            w_loaded_q    <= w_loaded_d;
            ld_cnt_q      <= ld_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            base_q        <= base_d;
            input_ready_q <= input_ready_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) w_mem[wr_addr] <= input_data;
        if (x_we) x_mem[wr_addr[XW-1:0]] <= input_data;
        if (rd_en) begin
            w_rd_q <= w_mem[rd_waddr];
            x_rd_q <= x_mem[rd_xaddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            rd_first_q <= rd_first;
            rd_last_q  <= rd_last;
        end
    end

    assign prod_c = PW'(w_rd_q) * PW'(x_rd_q);

    generate
        if (MULT_STAGES == 0) begin : g_nopipe
            assign m_prod  = prod_c;
            assign m_vld   = rd_vld_q;
            assign m_first = rd_first_q;
            assign m_last  = rd_last_q;
        end else begin : g_pipe
            logic signed [PW-1:0]   pp_q [MULT_STAGES];
            logic [MULT_STAGES-1:0] pv_q, pf_q, pl_q;
            always_ff @(posedge clk) begin
                pp_q[0] <= prod_c;
                for (int i = 1; i < MULT_STAGES; i++) pp_q[i] <= pp_q[i-1];
            end
            always_ff @(posedge clk) begin
                if (!reset) begin
                    pv_q <= '0;
                    pf_q <= '0;
                    pl_q <= '0;
                end else begin
                    pv_q[0] <= rd_vld_q;
                    pf_q[0] <= rd_first_q;
                    pl_q[0] <= rd_last_q;
                    for (int i = 1; i < MULT_STAGES; i++) begin
                        pv_q[i] <= pv_q[i-1];
                        pf_q[i] <= pf_q[i-1];
                        pl_q[i] <= pl_q[i-1];
                    end
                end
            end
            assign m_prod  = pp_q[MULT_STAGES-1];
            assign m_vld   = pv_q[MULT_STAGES-1];
            assign m_first = pf_q[MULT_STAGES-1];
            assign m_last  = pl_q[MULT_STAGES-1];
        end
    endgenerate

    assign prod_ext = ACC_W'(m_prod);

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q      <= '0;
            acc_done_q <= 1'b0;
        end else begin
            if (m_vld) acc_q <= m_first ? prod_ext : acc_q + prod_ext;
            acc_done_q <= m_vld && m_last;
        end
    end
endmodule
